// File: rtl/mchub_pkg.sv
// rtl/mchub_pkg.sv - shared constants and helpers for the multicore I/O hub
package mchub_pkg;

    localparam int MCHUB_MAX_CORES = 64;
    localparam int MCHUB_MAX_IDX_W = 6;

    typedef logic [MCHUB_MAX_IDX_W-1:0] core_idx_t;

    // Tag for the widest hub; each instance keeps only its low core_idx_w(NCORES) bits.
    typedef struct packed {
        logic      valid;
        core_idx_t core;
    } fifo_tag_t;

    // A single core still needs one index bit so no zero-width vectors appear.
    function automatic int core_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mchub_rr_arb.sv
// rtl/mchub_rr_arb.sv - N-way round-robin arbiter, one-hot grant plus index
module mchub_rr_arb
    import mchub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req,
    input  logic                     adv,
    output logic [N-1:0]             grant,
    output logic [core_idx_w(N)-1:0] idx
);

    localparam int IW = core_idx_w(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // ptr_q holds the highest-priority index: one past the last winner.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[wrap(int'(ptr_q) + i)]) begin
                found                        = 1'b1;
                grant[wrap(int'(ptr_q) + i)] = 1'b1;
                idx                          = IW'(wrap(int'(ptr_q) + i));
            end
        end
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/multicore_io_hub.sv
// rtl/multicore_io_hub.sv - sample dispatch / result collect hub; MCHUB_TAG_EN adds out_core
module multicore_io_hub
    import mchub_pkg::*;
#(
    parameter int NCORES     = 41,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DW-1:0]                 in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NCORES-1:0]             req_in,
    output logic [DW-1:0]                 core_in_data,
    output logic [NCORES-1:0]             core_in_grant,
    input  logic [NCORES*DW-1:0]          core_out_data,
    input  logic [NCORES-1:0]             core_out_en,
    output logic [DW-1:0]                 out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
`ifdef MCHUB_TAG_EN
    output logic [core_idx_w(NCORES)-1:0] out_core,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int IW = core_idx_w(NCORES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef MCHUB_TAG_EN
    typedef struct packed {
        logic [IW-1:0] core;
        logic [DW-1:0] data;
    } entry_t;
`else
    typedef struct packed {
        logic [DW-1:0] data;
    } entry_t;
`endif

    logic [NCORES-1:0] disp_grant, drain_grant, drained;
    logic [IW-1:0]     disp_idx, drain_idx;
    logic [NCORES-1:0] pend_q, pend_d, load;
    logic [DW-1:0]     slot_q [NCORES];
    logic [DW-1:0]     slot_d [NCORES];
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            push_entry, head;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DW-1:0]     core_in_data_q, core_in_data_d;
    logic [NCORES-1:0] core_in_grant_q, core_in_grant_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, full;

    assign in_ready = in_valid && (|disp_grant) && !rst;
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = (count_q != '0) && out_ready;
    assign push     = (|drain_grant) && (!full || pop);

    mchub_rr_arb #(.N(NCORES)) u_disp_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_in),
        .adv   (in_ready),
        .grant (disp_grant),
        .idx   (disp_idx)
    );

    mchub_rr_arb #(.N(NCORES)) u_drain_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (pend_q),
        .adv   (push),
        .grant (drain_grant),
        .idx   (drain_idx)
    );

    always_comb begin
        core_in_data_d  = core_in_data_q;
        core_in_grant_d = '0;
        if (in_ready) begin
            core_in_data_d            = in_data;
            core_in_grant_d[disp_idx] = 1'b1;
        end

        // A slot drained this cycle is free again, so a same-cycle strobe is captured.
        drained    = push ? drain_grant : '0;
        load       = core_out_en & (~pend_q | drained);
        pend_d     = (pend_q & ~drained) | core_out_en;
        overflow_d = overflow_q | (|(core_out_en & pend_q & ~drained));
        for (int k = 0; k < NCORES; k++) begin
            slot_d[k] = load[k] ? core_out_data[k*DW +: DW] : slot_q[k];
        end

        push_entry      = '0;
        push_entry.data = slot_q[drain_idx];
`ifdef MCHUB_TAG_EN
        push_entry.core = drain_idx;
`endif
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            core_in_data_q  <= '0;
            core_in_grant_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            pend_q          <= pend_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            core_in_data_q  <= core_in_data_d;
            core_in_grant_q <= core_in_grant_d;
            overflow_q      <= overflow_d;
        end
    end

    // Storage needs no reset: pending bits and the count gate every read.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign out_valid     = (count_q != '0);
    assign out_data      = out_valid ? head.data : '0;
`ifdef MCHUB_TAG_EN
    assign out_core      = out_valid ? head.core : '0;
`endif
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign core_in_data  = core_in_data_q;
    assign core_in_grant = core_in_grant_q;

endmodule

// File: tb/tb_multicore_io_hub.sv
// tb/tb_multicore_io_hub.sv - randomized self-checking bench with queue-based reference model
module tb_multicore_io_hub;
    import mchub_pkg::*;

    localparam int NCORES = 41;
    localparam int DW     = 32;
    localparam int FD     = 16;
    localparam int CW     = $clog2(FD) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCORES-1:0]    req_in;
    logic [DW-1:0]        core_in_data;
    logic [NCORES-1:0]    core_in_grant;
    logic [NCORES*DW-1:0] core_out_data;
    logic [NCORES-1:0]    core_out_en;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overflow;
    logic [CW-1:0]        fifo_count;
`ifdef MCHUB_TAG_EN
    logic [core_idx_w(NCORES)-1:0] out_core;
`endif

    multicore_io_hub #(.NCORES(NCORES), .DW(DW), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .req_in        (req_in),
        .core_in_data  (core_in_data),
        .core_in_grant (core_in_grant),
        .core_out_data (core_out_data),
        .core_out_en   (core_out_en),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
`ifdef MCHUB_TAG_EN
        .out_core      (out_core),
`endif
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                m_disp_next, m_drain_next;
    logic [NCORES-1:0] m_pend;
    logic [DW-1:0]     m_slot [NCORES];
    logic [DW-1:0]     m_fifo_d [$];
    int                m_fifo_t [$];
    bit                m_ovf;
    logic [NCORES-1:0] m_grant;
    logic [DW-1:0]     m_cin;
    logic [DW-1:0]     obs_q [$];
    int                obs_t [$];
    int                t2_exp [6] = '{0, 1, 40, 0, 1, 40};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int rr_pick(input int start, input logic [NCORES-1:0] v);
        for (int i = 0; i < NCORES; i++) begin
            if (v[(start + i) % NCORES]) return (start + i) % NCORES;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_disp_next  = 0;
        m_drain_next = 0;
        m_pend       = '0;
        m_fifo_d.delete();
        m_fifo_t.delete();
        m_ovf        = 1'b0;
        m_grant      = '0;
        m_cin        = '0;
    endtask

    // Applies one clock edge of the hub's rules to the model, using the inputs held this cycle.
    task automatic model_step();
        int s, d, pre;
        bit do_pop;
        if (rst) begin
            model_clear();
            return;
        end
        m_grant = '0;
        s = in_valid ? rr_pick(m_disp_next, req_in) : -1;
        if (s >= 0) begin
            m_grant[s]  = 1'b1;
            m_cin       = in_data;
            m_disp_next = (s + 1) % NCORES;
        end
        pre    = m_fifo_d.size();
        do_pop = (pre > 0) && out_ready;
        d      = (pre < FD || do_pop) ? rr_pick(m_drain_next, m_pend) : -1;
        if (do_pop) begin
            void'(m_fifo_d.pop_front());
            void'(m_fifo_t.pop_front());
        end
        if (d >= 0) begin
            m_fifo_d.push_back(m_slot[d]);
            m_fifo_t.push_back(d);
            m_pend[d]    = 1'b0;
            m_drain_next = (d + 1) % NCORES;
        end
        for (int k = 0; k < NCORES; k++) begin
            if (core_out_en[k]) begin
                if (m_pend[k]) m_ovf = 1'b1;
                else begin
                    m_slot[k] = core_out_data[k*DW +: DW];
                    m_pend[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(!rst && in_valid && (|req_in)));
        check("core_in_grant", 64'(core_in_grant), 64'(m_grant));
        check("core_in_data", 64'(core_in_data), 64'(m_cin));
        check("out_valid", 64'(out_valid), 64'(m_fifo_d.size() > 0));
        check("fifo_count", 64'(fifo_count), 64'(m_fifo_d.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (m_fifo_d.size() > 0) begin
            check("out_data", 64'(out_data), 64'(m_fifo_d[0]));
`ifdef MCHUB_TAG_EN
            check("out_core", 64'(out_core), 64'(m_fifo_t[0]));
`endif
        end
        if (out_valid && out_ready) begin
            obs_q.push_back(out_data);
`ifdef MCHUB_TAG_EN
            obs_t.push_back(int'(out_core));
`endif
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        req_in      = '0;
        core_out_en = '0;
    endtask

    task automatic strobe(input int k, input logic [DW-1:0] v);
        core_out_en[k]            = 1'b1;
        core_out_data[k*DW +: DW] = v;
    endtask

    initial begin
        int cnt_d1, cnt_d2, en_mod;
        idle();
        rst           = 1'b1;
        out_ready     = 1'b0;
        core_out_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        cycle();
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);

        // Round-robin across cores 0, 1, 40
        idle();
        req_in[0]  = 1'b1;
        req_in[1]  = 1'b1;
        req_in[40] = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = DW'(i + 1);
            cycle();
            check("rr_grant", 64'(core_in_grant), 64'd1 << t2_exp[i]);
            check("rr_data", 64'(core_in_data), 64'(i + 1));
        end

        // Single requester core 5
        idle();
        req_in[5] = 1'b1;
        in_valid  = 1'b1;
        in_data   = 100;
        cycle();
        idle();
        check("single_grant", 64'(core_in_grant), 64'd1 << 5);
        check("single_data", 64'(core_in_data), 64'd100);
        cycle();
        check("single_grant_drop", 64'(core_in_grant), 64'd0);

        // Cores 3 and 7 strobe together
        out_ready = 1'b1;
        obs_q.delete();
        obs_t.delete();
        strobe(3, 11);
        strobe(7, 22);
        cycle();
        idle();
        repeat (6) cycle();
        check("pair_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() >= 2) begin
            check("pair_first", 64'(obs_q[0]), 64'd11);
            check("pair_second", 64'(obs_q[1]), 64'd22);
`ifdef MCHUB_TAG_EN
            check("pair_tag0", 64'(obs_t[0]), 64'd3);
            check("pair_tag1", 64'(obs_t[1]), 64'd7);
`endif
        end
        check("pair_overflow", 64'(overflow), 64'd0);

        // Fill the FIFO, then overflow slot 2
        out_ready = 1'b0;
        for (int k = 10; k < 26; k++) strobe(k, DW'(32'h1000 + k));
        cycle();
        idle();
        repeat (17) cycle();
        strobe(2, 32'hD1);
        cycle();
        idle();
        strobe(2, 32'hD2);
        cycle();
        idle();
        cycle();
        check("full_count", 64'(fifo_count), 64'd16);
        check("full_overflow", 64'(overflow), 64'd1);
        obs_q.delete();
        out_ready = 1'b1;
        cycle();
        check("poppush_count", 64'(fifo_count), 64'd16);
        repeat (20) cycle();
        cnt_d1 = 0;
        cnt_d2 = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i] == 32'hD1) cnt_d1++;
            if (obs_q[i] == 32'hD2) cnt_d2++;
        end
        check("kept_value_seen", 64'(cnt_d1), 64'd1);
        check("dropped_value_seen", 64'(cnt_d2), 64'd0);

        // Reset with 4 queued and 2 pending
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(k, DW'(32'h500 + k));
        cycle();
        idle();
        repeat (5) cycle();
        strobe(8, 32'h608);
        strobe(9, 32'h609);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_count", 64'(fifo_count), 64'd0);
        check("rst_mid_overflow", 64'(overflow), 64'd0);
        obs_q.delete();
        out_ready = 1'b1;
        repeat (5) cycle();
        check("rst_no_stale", 64'(obs_q.size()), 64'd0);

        // Randomized traffic: light load, then overload
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en_mod    = (cyc < 1500) ? 64 : 10;
            rst       = ($urandom_range(0, 499) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < NCORES; k++) begin
                req_in[k]                 = ($urandom_range(0, 3) == 0);
                core_out_en[k]            = ($urandom_range(0, en_mod - 1) == 0);
                core_out_data[k*DW +: DW] = $urandom;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicore_io_hub.md
# multicore_io_hub

Parametrised I/O hub between a single sample stream and an array of processing cores. It distributes input samples to requesting cores with round-robin fairness and merges per-core results into one ordered output stream through a buffered collector. It replaces ad-hoc "any core requests → read next sample / every enabled core writes" glue with a proper valid/ready interface, back-pressure and overflow detection.

## Interface
- `NCORES`, 41, number of cores served (1..64)
- `DW`, 32, sample/result width (signed data, treated as opaque bits)
- `FIFO_DEPTH`, 16, output FIFO entries (power of two, ≥2)
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_data` in DW: upstream sample
- `in_valid` in 1: upstream sample available
- `in_ready` out 1: sample consumed this cycle
- `req_in` in NCORES: per-core sample request (level)
- `core_in_data` out DW: registered sample, broadcast to all cores
- `core_in_grant` out NCORES: one-hot, marks the core that owns `core_in_data`
- `core_out_data` in NCORES*DW: per-core result, core k at bits [k*DW +: DW]
- `core_out_en` in NCORES: per-core result strobe (one cycle per result)
- `out_data` out DW: merged result
- `out_valid` out 1: FIFO not empty
- `out_ready` in 1: downstream accepts
- `overflow` out 1: sticky, a result was lost
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy

## Operation
- Dispatch: when `in_valid` and `|req_in`, round-robin arbiter picks one requester, starting after the last granted index (wraps NCORES-1 → 0); `in_ready`=1 combinationally that cycle. No requester or no `in_valid` → `in_ready`=0, pointer unchanged.
- Granted sample registered into `core_in_data`; `core_in_grant` one-hot for exactly one cycle, else all-zero.
- Collect: each core has a one-entry holding register (pending bit + DW data). `core_out_en[k]` loads slot k and sets pending.
- Strobe on a slot already pending and not drained that cycle → data dropped, old data kept, `overflow` set (cleared only by `rst`).
- Drain: one pending slot per cycle is pushed into the FIFO, chosen by a second round-robin pointer; push allowed when FIFO not full, or full with a pop the same cycle.
- FIFO full with no pop → no drain, pending slots hold (back-pressure only on the collector; cores may then hit overflow).
- Slot drained and re-strobed in the same cycle → new data captured, no overflow.
- Output: `out_data` = FIFO head; pop when `out_valid && out_ready`.

## Timing
- Reset values: `in_ready` 0 (combinational, forced 0 while `rst`), `core_in_data` 0, `core_in_grant` 0, `out_valid` 0, `out_data` 0, `overflow` 0, `fifo_count` 0, all pending bits 0, both RR pointers at core 0 (highest priority = index 0).
- Dispatch latency: sample accepted cycle t → `core_in_grant`/`core_in_data` valid cycle t+1.
- Result latency: `core_out_en` cycle t → slot pending t+1 → earliest FIFO entry t+2 → `out_valid` at t+2.
- Throughput: one sample in and one result out per cycle sustained.
- `rst` mid-operation: all pending data and FIFO contents discarded; no grant issued in the reset cycle.

## Configuration
- `MCHUB_TAG_EN` defined: additional output `out_core` ($clog2(NCORES) bits) carries the source core index with each FIFO entry; FIFO width DW+tag; reset value 0.
- Undefined: no `out_core` port, FIFO stores data only; ordering is still drain order.

## Structure
- Package `mchub_pkg`: `DW`-independent constants (`MCHUB_MAX_CORES`=64), core-index width function, FIFO entry struct (data + optional tag).
- Sub-module `mchub_rr_arb` (parametrised N-way round-robin, request vector + advance enable → one-hot grant + index), instantiated twice (dispatch and drain).
- FIFO is in-line (pointers + array), not a separate module.

## Test plan
- Single requester core 5, `in_data`=100 with `in_valid` → `core_in_grant`=1<<5 and `core_in_data`=100 the next cycle, `in_ready`=1 for one cycle only.
- Cores 0,1,40 request continuously, 6 samples 1..6 → grants 0,1,40,0,1,40 in order.
- Cores 3 and 7 strobe 11 and 22 same cycle, `out_ready`=1 → outputs 11 then 22 (tag 3, 7 with `MCHUB_TAG_EN`), `overflow`=0.
- `out_ready`=0, 16 results fill FIFO, core 2 strobes twice more → `fifo_count`=16, `overflow`=1, first dropped value never appears after releasing `out_ready`.
- FIFO full, `out_ready`=1 and pending slot present → simultaneous pop/push, `fifo_count` stays 16.
- `rst` asserted with 4 FIFO entries and 2 pending → next cycle `out_valid`=0, `fifo_count`=0, no stale data emitted afterwards.
